// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Round-robin owner arbiter for the single VGA pixel-write port. One drawing
//   engine owns the port from grant until it drops req, so a multi-pixel burst
//   is never interleaved with another engine's pixels. Pixel data is muxed
//   only from the current owner and registered once before reaching the
//   vga_adapter inputs.
//   Optional feature macro: VGA_ARB_WATCHDOG_EN -- bounds each ownership to
//   TIMEOUT cycles and pulses `timeout` on a forced release. Without it the
//   ownership is unbounded and `timeout` stays low.
module vga_plot_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int C_W     = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       plot_in,
    input  logic [N_REQ*X_W-1:0]   x_in,
    input  logic [N_REQ*Y_W-1:0]   y_in,
    input  logic [N_REQ*C_W-1:0]   color_in,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   vga_plot,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_color,
    output logic                   timeout
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Elaboration-time parameter sanity checks.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("vga_plot_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("vga_plot_arbiter: TIMEOUT must be at least 2");
    end

    logic [1:0]         state;
    logic [PTR_W-1:0]   ptr;        // last winner; doubles as the owner index
    logic [N_REQ-1:0]   eff_req;    // requests eligible for arbitration
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   cand;
    logic               found;
    int                 rr_idx;
    logic               owner_req;
    logic               owner_plot;
    logic               force_rel;  // watchdog forced release this cycle

    assign owner_req  = req[ptr];
    assign owner_plot = plot_in[ptr];

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef VGA_ARB_WATCHDOG_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] hold_cnt;
    logic [N_REQ-1:0] blocked;      // timed-out owners wait for a req drop

    assign eff_req   = req & ~blocked;
    assign force_rel = (state == ST_OWN) && owner_req &&
                       (hold_cnt == CNT_W'(TIMEOUT - 1));

    // Hold counter: zero while idle so it starts at 0 on entry to OWN.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_cnt <= {CNT_W{1'b0}};
        end else if (state == ST_IDLE) begin
            hold_cnt <= {CNT_W{1'b0}};
        end else if (state == ST_OWN) begin
            hold_cnt <= hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            hold_cnt <= hold_cnt;
        end
    end

    // Block a force-released owner until it drops its req at least once.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            blocked <= {N_REQ{1'b0}};
        end else if (force_rel) begin
            blocked <= (blocked & req) | grant;
        end else begin
            blocked <= blocked & req;
        end
    end
`else
    assign eff_req   = req;
    assign force_rel = 1'b0;
`endif

    // Round-robin pick: first eligible request after the last winner.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        rr_idx = 0;
        cand   = {PTR_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = (int'(ptr) + k) % N_REQ;
            cand   = PTR_W'(rr_idx);
            if (!found && eff_req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end else begin
                winner = winner;
            end
        end
    end

    // Ownership FSM and registered VGA write port.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            ptr       <= PTR_W'(N_REQ - 1);
            grant     <= {N_REQ{1'b0}};
            busy      <= 1'b0;
            vga_plot  <= 1'b0;
            vga_x     <= {X_W{1'b0}};
            vga_y     <= {Y_W{1'b0}};
            vga_color <= {C_W{1'b0}};
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    vga_plot <= 1'b0;
                    if (found) begin
                        grant <= onehot(winner);
                        busy  <= 1'b1;
                        ptr   <= winner;
                        state <= ST_OWN;
                    end else begin
                        grant <= {N_REQ{1'b0}};
                        busy  <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (!owner_req || force_rel) begin
                        grant    <= {N_REQ{1'b0}};
                        busy     <= 1'b0;
                        vga_plot <= 1'b0;
                        timeout  <= force_rel;
                        state    <= ST_GAP;
                    end else begin
                        vga_plot <= owner_plot;
                        // Coordinates only move with a real pixel so they
                        // hold their last value while vga_plot is low.
                        if (owner_plot) begin
                            vga_x     <= x_in[ptr*X_W +: X_W];
                            vga_y     <= y_in[ptr*Y_W +: Y_W];
                            vga_color <= color_in[ptr*C_W +: C_W];
                        end else begin
                            vga_x     <= vga_x;
                            vga_y     <= vga_y;
                            vga_color <= vga_color;
                        end
                    end
                end
                ST_GAP: begin
                    grant    <= {N_REQ{1'b0}};
                    busy     <= 1'b0;
                    vga_plot <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    grant    <= {N_REQ{1'b0}};
                    busy     <= 1'b0;
                    vga_plot <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter (N_REQ=4, TIMEOUT=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected pixels are queued when driven to the owner and compared when
// vga_plot appears.
module tb_vga_plot_arbiter;

    localparam int N  = 4;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      req;
    logic [N-1:0]      plot_in;
    logic [N*XW-1:0]   x_in;
    logic [N*YW-1:0]   y_in;
    logic [N*CW-1:0]   color_in;
    logic [N-1:0]      grant;
    logic              busy;
    logic              vga_plot;
    logic [XW-1:0]     vga_x;
    logic [YW-1:0]     vga_y;
    logic [CW-1:0]     vga_color;
    logic              timeout;

    int checks = 0;
    int fails  = 0;

    logic [XW+YW+CW-1:0] exp_q[$];
    logic [XW+YW+CW-1:0] mon_exp;

    vga_plot_arbiter #(.N_REQ(N), .TIMEOUT(8), .X_W(XW), .Y_W(YW), .C_W(CW)) dut (
        .clk(clk), .resetn(resetn), .req(req), .plot_in(plot_in),
        .x_in(x_in), .y_in(y_in), .color_in(color_in),
        .grant(grant), .busy(busy), .vga_plot(vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard: every forwarded pixel must match the oldest queued one.
    always @(negedge clk) begin
        if (resetn === 1'b1 && vga_plot === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, required no plot",
                         vga_x, vga_y, vga_color);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({vga_x, vga_y, vga_color} !== mon_exp) begin
                    fails++;
                    $display("FAIL pixel_data: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                             vga_x, vga_y, vga_color,
                             mon_exp[XW+YW+CW-1 -: XW], mon_exp[YW+CW-1 -: YW], mon_exp[CW-1:0]);
                end
            end
        end
    end

    task automatic clear_inputs();
        req = '0; plot_in = '0; x_in = '0; y_in = '0; color_in = '0;
    endtask

    task automatic set_pix(input int i, input logic [XW-1:0] x,
                           input logic [YW-1:0] y, input logic [CW-1:0] c, input logic push);
        x_in[i*XW +: XW]     = x;
        y_in[i*YW +: YW]     = y;
        color_in[i*CW +: CW] = c;
        plot_in[i]           = 1'b1;
        if (push) exp_q.push_back({x, y, c});
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_grant(input logic [N-1:0] exp, input string name);
        int n = 0;
        while (grant === 4'b0000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (grant !== exp) begin
            fails++;
            $display("FAIL %s: grant got %b, required %b", name, grant, exp);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        req    = 4'b1111;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, busy, vga_plot, vga_x, vga_y, vga_color, timeout} !== '0) begin
            fails++;
            $display("FAIL reset_state: grant=%b busy=%b plot=%b x=%0d y=%0d c=%0d to=%b, required all 0",
                     grant, busy, vga_plot, vga_x, vga_y, vga_color, timeout);
        end
        req    = 4'b0000;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        req[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: grant=%b busy=%b, required 0100 1", grant, busy);
        end
        set_pix(2, 9'd37, 8'd20, 3'b100, 1'b1);
        @(negedge clk);
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 9'd37 || vga_y !== 8'd20) begin
            fails++;
            $display("FAIL single_pixel: plot=%b x=%0d y=%0d, required 1 37 20", vga_plot, vga_x, vga_y);
        end
        plot_in = '0;
        req     = '0;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || vga_plot !== 1'b0 || vga_x !== 9'd37) begin
            fails++;
            $display("FAIL single_release: grant=%b plot=%b x=%0d, required 0000 0 37 (held)",
                     grant, vga_plot, vga_x);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int gaps;
        int o;
        do_reset();
        req = 4'b1111;
        wait_grant(4'b0001, "rr_first");
        for (int n = 0; n < 5; n++) begin
            o = n % N;
            checks++;
            if (grant !== (4'b0001 << o)) begin
                fails++;
                $display("FAIL rr_order[%0d]: grant got %b, required %b", n, grant, 4'b0001 << o);
            end
            if (n == 4) break;
            for (int k = 0; k < 16; k++) begin
                set_pix(o, XW'(o * 60 + k), YW'(o * 10 + k), CW'(k), 1'b1);
                @(negedge clk);
            end
            plot_in = '0;
            req[o]  = 1'b0;
            @(negedge clk);
            req[o] = 1'b1;
            gaps   = 0;
            while (grant === 4'b0000 && gaps < 20) begin
                gaps++;
                @(negedge clk);
            end
            checks++;
            if (gaps != 2) begin
                fails++;
                $display("FAIL rr_gap[%0d]: idle grant cycles got %0d, required 2", n, gaps);
            end
        end
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_isolation();
        logic bad = 1'b0;
        do_reset();
        req[1] = 1'b1;
        wait_grant(4'b0010, "iso_grant");
        req[3] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_pix(1, XW'(10 + k), 8'd5, 3'b001, 1'b1);
            set_pix(3, 9'd300, 8'd99, 3'b111, 1'b0);
            @(negedge clk);
            if (vga_x === 9'd300 || grant !== 4'b0010) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL isolation: non-owner data reached port (x=%0d grant=%b), required x!=300 grant 0010",
                     vga_x, grant);
        end
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1000;
        wait_grant(4'b1000, "wrap_owner3");
        req = 4'b0011;
        @(negedge clk);
        wait_grant(4'b0001, "wrap_to_0");
        req[0] = 1'b0;
        @(negedge clk);
        wait_grant(4'b0010, "wrap_then_1");
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_short_grant();
        req[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("FAIL short_grant: grant got %b, required 0100", grant);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || vga_plot !== 1'b0) begin
            fails++;
            $display("FAIL short_release: grant=%b plot=%b, required 0000 0", grant, vga_plot);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req[0] = 1'b1;
        wait_grant(4'b0001, "mid_grant");
        set_pix(0, 9'd123, 8'd45, 3'b011, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant, busy, vga_plot, vga_x, vga_y, vga_color} !== '0) begin
            fails++;
            $display("FAIL reset_mid_burst: grant=%b busy=%b plot=%b x=%0d, required all 0",
                     grant, busy, vga_plot, vga_x);
        end
        clear_inputs();
        resetn = 1'b1;
        @(negedge clk);
    endtask

`ifdef VGA_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int held = 1;
        int tcnt = 0;
        int g = 0;
        int n = 0;
        do_reset();
        req[0] = 1'b1;
        wait_grant(4'b0001, "wd_grant0");
        req[1] = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (timeout === 1'b1) tcnt++;
            if (grant !== 4'b0001) break;
            held++;
        end
        while (grant === 4'b0000 && g < 20) begin
            g++;
            @(negedge clk);
            if (timeout === 1'b1) tcnt++;
        end
        checks++;
        if (held != 8 || g != 2 || grant !== 4'b0010 || tcnt != 1) begin
            fails++;
            $display("FAIL watchdog: held=%0d gap=%0d grant=%b pulses=%0d, required 8 2 0010 1",
                     held, g, grant, tcnt);
        end
        req[1] = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin
            fails++;
            $display("FAIL watchdog_requeue: grant got %b, required 0000 until req re-raised", grant);
        end
        req[0] = 1'b0;
        @(negedge clk);
        req[0] = 1'b1;
        @(negedge clk);
        wait_grant(4'b0001, "watchdog_regrant");
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask
`else
    task automatic test_watchdog();
        logic bad = 1'b0;
        do_reset();
        req = 4'b0011;
        wait_grant(4'b0001, "nowd_grant0");
        repeat (40) begin
            @(negedge clk);
            if (grant !== 4'b0001 || timeout !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL no_watchdog: grant=%b timeout=%b, required 0001 0 throughout", grant, timeout);
        end
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        clear_inputs();
        resetn = 1'b0;
        test_reset();
        test_single();
        test_short_grant();
        test_round_robin();
        test_isolation();
        test_wrap();
        test_watchdog();
        test_reset_mid_burst();
        exp_q.delete();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d pixels left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "time limit");
    end

endmodule
